signed_shift_right_round: RTL and testbench
===========================================

SIGNED_SHIFT_RIGHT_ROUND -- requirements
Module: signed_shift_right_round

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the width of the signed two's-complement operand and result.
REQ-002 Parameter SHAMT_WIDTH, default 4, SHALL set the shift-amount width; shift range is 0..2^SHAMT_WIDTH-1 (radix-16 digit).
REQ-003 Parameter STEP, default 4, SHALL set the maximum number of bit positions shifted per cycle.
REQ-004 The legal parameter set SHALL satisfy 2^SHAMT_WIDTH-1 < DATA_WIDTH and 1 <= STEP <= 2^SHAMT_WIDTH-1; other values are unsupported.
REQ-005 iClk  input  1  the single clock; all state updates on its rising edge.
REQ-006 iRst_n  input  1  asynchronous, active-low reset.
REQ-007 iValid  input  1  operand offer.
REQ-008 oReady  output  1  block can accept an operand.
REQ-009 iDat  input  DATA_WIDTH  signed operand.
REQ-010 iShamt  input  SHAMT_WIDTH  unsigned right-shift amount s.
REQ-011 oValid  output  1  result available.
REQ-012 iReady  input  1  downstream accepts the result.
REQ-013 oDat  output  DATA_WIDTH  signed rounded result.
REQ-014 oBusy  output  1  high in any state other than IDLE.

Function
REQ-015 The block SHALL compute oDat = floor((iDat + 2^(s-1)) / 2^s) for s>0 (round half toward +infinity) and oDat = iDat for s=0; the result always fits in DATA_WIDTH, no saturation needed.
REQ-016 Rounding SHALL be realised as arithmetic (sign-filling) right shift plus the guard bit, the last bit shifted out (bit s-1 of iDat).
REQ-017 State machine SHALL have states IDLE, SHIFT, DONE.
REQ-018 oReady SHALL equal (state==IDLE); oValid SHALL equal (state==DONE).
REQ-019 IDLE: on an edge with iValid=1, the block SHALL load acc=iDat, rem=iShamt, guard=0; next state DONE with oDat<=iDat if iShamt=0, else SHIFT.
REQ-020 SHIFT: each edge SHALL arithmetic-shift acc right by k=min(STEP,rem), set guard to the last bit shifted out, and set rem=rem-k.
REQ-021 SHIFT: when rem-k=0 the same edge SHALL load oDat with shifted acc + guard and move to DONE; otherwise remain in SHIFT.
REQ-022 Latency from accept edge to first cycle with oValid=1 SHALL be exactly 1+ceil(s/STEP) cycles (1 for s=0).
REQ-023 DONE: oDat and oValid SHALL hold stable until an edge with iReady=1, which returns state to IDLE; oValid then drops the following cycle.
REQ-024 iValid, iDat and iShamt SHALL be ignored outside IDLE; no operand is queued.
REQ-025 Throughput SHALL be one operation per 2+ceil(s/STEP) cycles with iReady held high.

Reset
REQ-026 iRst_n low SHALL immediately force state=IDLE, oValid=0, oBusy=0, oDat=0, acc=0, rem=0, guard=0, independent of iClk.
REQ-027 Reset asserted in SHIFT or DONE SHALL abort the operation with no result delivered; first accept is possible on the first rising edge after iRst_n deasserts.
REQ-028 oReady SHALL be 1 during reset (state IDLE), but no operand SHALL be accepted while iRst_n is low.

Verification
REQ-029 iDat=0x7FFF, s=0, iReady=1 -> oDat=0x7FFF, oValid high 1 cycle after accept, for one cycle.
REQ-030 iDat=0x0006, s=2 -> oDat=0x0002 after 2 cycles; iDat=0xFFFA, s=2 -> oDat=0xFFFF (-1.5 rounds to -1).
REQ-031 iDat=0x0130, s=5 -> oDat=0x000A, latency 3 cycles; iDat=0x8000, s=15 -> oDat=0xFFFF, latency 5 cycles.
REQ-032 Backpressure: result 0x000A in DONE, iReady=0 for 3 cycles with a new iValid=1 offered -> oDat/oValid stable, oReady=0, offer not accepted; iReady=1 -> IDLE next cycle, then offer accepted.
REQ-033 Reset mid-SHIFT (s=15, iRst_n low after 2 SHIFT cycles) -> oValid=0, oDat=0, oBusy=0 immediately; after release, iDat=0x0006, s=2 yields 0x0002.
REQ-034 Random sweep of all s in 0..15 and 10k random iDat -> every oDat matches the REQ-015 reference model and every latency matches REQ-022.

Source files
------------

// File: rtl/signed_shift_right_round.sv
// Multi-cycle signed arithmetic right shift with round-half-up, STEP bits per cycle.
// The accumulator is shifted in chunks, and the last bit shifted out is added back as the rounding increment.
module signed_shift_right_round #(
  parameter int DATA_WIDTH  = 16,
  parameter int SHAMT_WIDTH = 4,
  parameter int STEP        = 4
) (
  input  logic                   iClk,
  input  logic                   iRst_n,
  input  logic                   iValid,
  output logic                   oReady,
  input  logic [DATA_WIDTH-1:0]  iDat,
  input  logic [SHAMT_WIDTH-1:0] iShamt,
  output logic                   oValid,
  input  logic                   iReady,
  output logic [DATA_WIDTH-1:0]  oDat,
  output logic                   oBusy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [SHAMT_WIDTH-1:0] STEP_W = SHAMT_WIDTH'(STEP);

  state_t                 state_q;
  logic [DATA_WIDTH-1:0]  acc_q;
  logic [SHAMT_WIDTH-1:0] rem_q;
  logic                   guard_q;
  logic [DATA_WIDTH-1:0]  odat_q;

  logic [SHAMT_WIDTH-1:0] k_s;
  logic [DATA_WIDTH-1:0]  shifted_s;
  logic [DATA_WIDTH-1:0]  lost_s;
  logic                   guard_s;
  logic [DATA_WIDTH-1:0]  rounded_s;

  // One SHIFT step: k = min(STEP, rem); the guard is the last bit pushed out (acc bit k-1).
  always_comb begin
    k_s       = STEP_W;
    shifted_s = acc_q;
    lost_s    = acc_q;
    guard_s   = 1'b0;
    rounded_s = acc_q;
    if (rem_q < STEP_W) begin
      k_s = rem_q;
    end else begin
      k_s = STEP_W;
    end
    shifted_s = DATA_WIDTH'($signed(acc_q) >>> k_s);
    lost_s    = acc_q >> (k_s - SHAMT_WIDTH'(1));
    guard_s   = lost_s[0];
    rounded_s = shifted_s + {{(DATA_WIDTH-1){1'b0}}, guard_s};
  end

  // Control FSM and datapath registers.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= IDLE;
      acc_q   <= {DATA_WIDTH{1'b0}};
      rem_q   <= {SHAMT_WIDTH{1'b0}};
      guard_q <= 1'b0;
      odat_q  <= {DATA_WIDTH{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (iValid) begin
            acc_q   <= iDat;
            rem_q   <= iShamt;
            guard_q <= 1'b0;
            if (iShamt == {SHAMT_WIDTH{1'b0}}) begin
              odat_q  <= iDat;
              state_q <= DONE;
            end else begin
              state_q <= SHIFT;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          acc_q   <= shifted_s;
          guard_q <= guard_s;
          rem_q   <= rem_q - k_s;
          if (rem_q == k_s) begin
            odat_q  <= rounded_s;
            state_q <= DONE;
          end else begin
            state_q <= SHIFT;
          end
        end
        DONE: begin
          if (iReady) begin
            state_q <= IDLE;
          end else begin
            state_q <= DONE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign oReady = (state_q == IDLE);
  assign oValid = (state_q == DONE);
  assign oBusy  = (state_q != IDLE);
  assign oDat   = odat_q;

endmodule

// File: tb/tb_signed_shift_right_round.sv
// Directed-vector and random-sweep bench for signed_shift_right_round.
module tb_signed_shift_right_round;

  logic        iClk;
  logic        iRst_n;
  logic        iValid;
  logic        oReady;
  logic [15:0] iDat;
  logic [3:0]  iShamt;
  logic        oValid;
  logic        iReady;
  logic [15:0] oDat;
  logic        oBusy;

  int n_checks;
  int n_errors;

  typedef struct {
    logic [15:0] dat;
    logic [3:0]  sh;
    logic [15:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs [14];

  signed_shift_right_round #(
    .DATA_WIDTH(16),
    .SHAMT_WIDTH(4),
    .STEP(4)
  ) dut (
    .iClk(iClk),
    .iRst_n(iRst_n),
    .iValid(iValid),
    .oReady(oReady),
    .iDat(iDat),
    .iShamt(iShamt),
    .oValid(oValid),
    .iReady(iReady),
    .oDat(oDat),
    .oBusy(oBusy)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_round(input logic [15:0] d, input logic [3:0] s);
    logic signed [31:0] sd;
    logic signed [31:0] r;
    sd = 32'(signed'(d));
    if (s == 4'd0) begin
      r = sd;
    end else begin
      r = (sd + (32'sd1 <<< (s - 4'd1))) >>> s;
    end
    return r[15:0];
  endfunction

  // Offer an operand with iReady high, measure latency, check result and one-cycle oValid.
  task automatic do_op(input logic [15:0] d, input logic [3:0] s,
                       input logic [15:0] exp, input int lat, input string name);
    int cyc;
    @(negedge iClk);
    iValid = 1'b1;
    iDat   = d;
    iShamt = s;
    iReady = 1'b1;
    check({name, "_ready"}, 32'(oReady), 32'd1);
    @(posedge iClk);
    #1;
    iValid = 1'b0;
    cyc = 1;
    while (!oValid && cyc < 40) begin
      @(posedge iClk);
      #1;
      cyc++;
    end
    check({name, "_valid"}, 32'(oValid), 32'd1);
    check({name, "_dat"}, 32'(oDat), 32'(exp));
    check({name, "_lat"}, 32'(cyc), 32'(lat));
    @(posedge iClk);
    #1;
    check({name, "_vdrop"}, 32'(oValid), 32'd0);
  endtask

  initial begin
    int cyc;
    logic [15:0] rd;
    logic [3:0]  rs;

    n_checks = 0;
    n_errors = 0;

    vecs[0]  = '{16'h7FFF, 4'd0,  16'h7FFF, 1};
    vecs[1]  = '{16'h0006, 4'd2,  16'h0002, 2};
    vecs[2]  = '{16'hFFFA, 4'd2,  16'hFFFF, 2};
    vecs[3]  = '{16'h0130, 4'd5,  16'h000A, 3};
    vecs[4]  = '{16'h8000, 4'd15, 16'hFFFF, 5};
    vecs[5]  = '{16'h7FFF, 4'd15, 16'h0001, 5};
    vecs[6]  = '{16'h0005, 4'd1,  16'h0003, 2};
    vecs[7]  = '{16'hFFFB, 4'd1,  16'hFFFE, 2};
    vecs[8]  = '{16'h0007, 4'd4,  16'h0000, 2};
    vecs[9]  = '{16'h0008, 4'd4,  16'h0001, 2};
    vecs[10] = '{16'hFFF8, 4'd4,  16'h0000, 2};
    vecs[11] = '{16'hFFF7, 4'd4,  16'hFFFF, 2};
    vecs[12] = '{16'h1234, 4'd8,  16'h0012, 3};
    vecs[13] = '{16'hFFFF, 4'd3,  16'h0000, 2};

    iRst_n = 1'b0;
    iValid = 1'b0;
    iDat   = 16'h0000;
    iShamt = 4'd0;
    iReady = 1'b1;
    #1;
    check("rst_ready", 32'(oReady), 32'd1);
    check("rst_valid", 32'(oValid), 32'd0);
    check("rst_busy",  32'(oBusy),  32'd0);
    check("rst_dat",   32'(oDat),   32'd0);
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    iRst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      do_op(vecs[i].dat, vecs[i].sh, vecs[i].exp, vecs[i].lat, $sformatf("vec%0d", i));
    end

    // Backpressure: result held in DONE while a new offer is ignored.
    @(negedge iClk);
    iValid = 1'b1; iDat = 16'h0130; iShamt = 4'd5; iReady = 1'b0;
    @(posedge iClk);
    #1;
    iDat = 16'h0006; iShamt = 4'd2;
    cyc = 1;
    while (!oValid && cyc < 40) begin
      @(posedge iClk);
      #1;
      cyc++;
    end
    check("bp_lat", 32'(cyc), 32'd3);
    for (int j = 0; j < 3; j++) begin
      @(posedge iClk);
      #1;
      check("bp_hold_valid", 32'(oValid), 32'd1);
      check("bp_hold_dat",   32'(oDat),   32'h000A);
      check("bp_hold_ready", 32'(oReady), 32'd0);
    end
    @(negedge iClk);
    iReady = 1'b1;
    @(posedge iClk);
    #1;
    check("bp_idle_valid", 32'(oValid), 32'd0);
    check("bp_idle_ready", 32'(oReady), 32'd1);
    @(posedge iClk);
    #1;
    iValid = 1'b0;
    check("bp_accept_busy", 32'(oBusy), 32'd1);
    cyc = 1;
    while (!oValid && cyc < 40) begin
      @(posedge iClk);
      #1;
      cyc++;
    end
    check("bp_new_lat", 32'(cyc), 32'd2);
    check("bp_new_dat", 32'(oDat), 32'h0002);
    @(posedge iClk);
    #1;

    // Reset in the middle of a long shift.
    @(negedge iClk);
    iValid = 1'b1; iDat = 16'h8000; iShamt = 4'd15;
    @(posedge iClk);
    #1;
    iValid = 1'b0;
    repeat (2) @(posedge iClk);
    #2;
    check("mid_busy_pre", 32'(oBusy), 32'd1);
    iRst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(oValid), 32'd0);
    check("mid_rst_dat",   32'(oDat),   32'd0);
    check("mid_rst_busy",  32'(oBusy),  32'd0);
    check("mid_rst_ready", 32'(oReady), 32'd1);
    iValid = 1'b1; iDat = 16'h1111; iShamt = 4'd0;
    @(posedge iClk);
    #1;
    check("rst_no_accept", 32'(oBusy), 32'd0);
    @(negedge iClk);
    iValid = 1'b0;
    iRst_n = 1'b1;
    do_op(16'h0006, 4'd2, 16'h0002, 2, "post_rst");

    // Random sweep across every shift amount against the arithmetic reference.
    for (int n = 0; n < 10000; n++) begin
      rd = 16'($urandom);
      rs = 4'(n % 16);
      do_op(rd, rs, ref_round(rd, rs), 1 + (int'(rs) + 3) / 4, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
